// File: rtl/reg_file_write_arbiter_pkg.sv
// Shared constants, payload type and helpers for the register-file write arbiter.
// Holds the core widths, the FSM state encoding, the sweep range and the
// {addr, data} write payload used by the arbiter and its aux FIFO.
package reg_file_write_arbiter_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned REG_ADDR_WIDTH   = 5;
  localparam int unsigned NUM_REGS         = 1 << REG_ADDR_WIDTH;
  localparam int unsigned FIFO_DEPTH       = 2;
  localparam int unsigned STARVE_CNT_WIDTH = 4;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // x0 is hardwired, so the sweep covers x1..x(NUM_REGS-1)
  localparam logic [REG_ADDR_WIDTH-1:0] SWEEP_FIRST = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] SWEEP_LAST  = REG_ADDR_WIDTH'(NUM_REGS - 1);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0]           data;
  } rf_write_t;

  function automatic logic [NUM_REGS-1:0] addr_one_hot(input logic [REG_ADDR_WIDTH-1:0] addr);
    addr_one_hot = NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/reg_write_fifo.sv
// Two-entry FIFO of pending aux register writes.
// Ports: i_Clock, i_Reset (sync, active-high); i_Push/i_Push_Entry enqueue;
// i_Pop drops the head; o_Head, o_Empty, o_Full; o_Entry_Valid/o_Entry_Addr
// expose every slot so the owner can build a pending-write mask.
module reg_write_fifo
  import reg_file_write_arbiter_pkg::*;
(
  input  logic                                        i_Clock,
  input  logic                                        i_Reset,
  input  logic                                        i_Push,
  input  rf_write_t                                   i_Push_Entry,
  input  logic                                        i_Pop,
  output rf_write_t                                   o_Head,
  output logic                                        o_Empty,
  output logic                                        o_Full,
  output logic [FIFO_DEPTH-1:0]                       o_Entry_Valid,
  output logic [FIFO_DEPTH-1:0][REG_ADDR_WIDTH-1:0]   o_Entry_Addr
);

  rf_write_t [FIFO_DEPTH-1:0] slot_q, slot_n;
  logic      [FIFO_DEPTH-1:0] valid_q, valid_n;

  // Shift organisation: slot 0 is always the head, so valid[1] implies valid[0]
  always_comb begin
    slot_n  = slot_q;
    valid_n = valid_q;
    if (i_Pop) begin
      slot_n[0]  = slot_q[1];
      valid_n[0] = valid_q[1];
      valid_n[1] = 1'b0;
    end
    if (i_Push) begin
      if (!valid_n[0]) begin
        slot_n[0]  = i_Push_Entry;
        valid_n[0] = 1'b1;
      end else begin
        slot_n[1]  = i_Push_Entry;
        valid_n[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      slot_q  <= '0;
      valid_q <= '0;
    end else begin
      slot_q  <= slot_n;
      valid_q <= valid_n;
    end
  end

  assign o_Head        = slot_q[0];
  assign o_Empty       = !valid_q[0];
  assign o_Full        = valid_q[FIFO_DEPTH-1];
  assign o_Entry_Valid = valid_q;

  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_addr
    assign o_Entry_Addr[g] = slot_q[g].addr;
  end

endmodule

// File: rtl/reg_file_write_arbiter.sv
// Owner of the register file write port.
// After reset it zeroes x1..x31, then arbitrates the port between writeback
// (priority, zero latency) and a 2-entry aux FIFO, exporting a pending-write
// mask and a starvation-driven stall request.
// Ports: i_Clock, i_Reset (sync, active-high); i_WB_* writeback request;
// i_Aux_*/o_Aux_Ready aux request handshake; o_RF_* register file port;
// o_Init_Done, o_Pending_Mask, o_Stall_Req to the hazard logic.
module reg_file_write_arbiter
  import reg_file_write_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_WB_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_WB_Addr,
  input  logic [XLEN-1:0]           i_WB_Data,
  input  logic                      i_Aux_Valid,
  output logic                      o_Aux_Ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_Aux_Addr,
  input  logic [XLEN-1:0]           i_Aux_Data,
  output logic                      o_RF_Enable,
  output logic                      o_RF_Write_Enable,
  output logic [REG_ADDR_WIDTH-1:0] o_RF_Write_Addr,
  output logic [XLEN-1:0]           o_RF_Write_Data,
  output logic                      o_Init_Done,
  output logic [NUM_REGS-1:0]       o_Pending_Mask,
  output logic                      o_Stall_Req
);

  localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  logic [0:0]                  state_q, state_n;
  logic [REG_ADDR_WIDTH-1:0]   sweep_q, sweep_n;
  logic [STARVE_CNT_WIDTH-1:0] starve_q, starve_n;
  logic                        init_done_q, init_done_n;
  logic                        stall_q, stall_n;

  logic                                      in_run;
  logic                                      aux_ready;
  logic                                      push;
  logic                                      pop;
  rf_write_t                                 push_entry;
  rf_write_t                                 fifo_head;
  logic                                      fifo_empty;
  logic                                      fifo_full;
  logic [FIFO_DEPTH-1:0]                     entry_valid;
  logic [FIFO_DEPTH-1:0][REG_ADDR_WIDTH-1:0] entry_addr;

  // Handshake from registered state only; x0 writes are acknowledged and dropped
  assign in_run     = (state_q == ST_RUN);
  assign aux_ready  = in_run && !fifo_full;
  assign push       = !i_Reset && i_Aux_Valid && aux_ready && (i_Aux_Addr != '0);
  assign pop        = !i_Reset && in_run && !i_WB_Valid && !fifo_empty;
  assign push_entry = '{addr: i_Aux_Addr, data: i_Aux_Data};

  reg_write_fifo u_fifo (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_Push        (push),
    .i_Push_Entry  (push_entry),
    .i_Pop         (pop),
    .o_Head        (fifo_head),
    .o_Empty       (fifo_empty),
    .o_Full        (fifo_full),
    .o_Entry_Valid (entry_valid),
    .o_Entry_Addr  (entry_addr)
  );

  // Write port mux: sweep in CLEAR, then WB over FIFO head; all quiet in reset
  always_comb begin
    o_RF_Enable       = !i_Reset;
    o_RF_Write_Enable = 1'b0;
    o_RF_Write_Addr   = '0;
    o_RF_Write_Data   = '0;
    if (!i_Reset) begin
      if (!in_run) begin
        o_RF_Write_Enable = 1'b1;
        o_RF_Write_Addr   = sweep_q;
      end else if (i_WB_Valid) begin
        o_RF_Write_Enable = 1'b1;
        o_RF_Write_Addr   = i_WB_Addr;
        o_RF_Write_Data   = i_WB_Data;
      end else if (!fifo_empty) begin
        o_RF_Write_Enable = 1'b1;
        o_RF_Write_Addr   = fifo_head.addr;
        o_RF_Write_Data   = fifo_head.data;
      end
    end
  end

  // Pending mask from queued entries; x0 can never be pending
  always_comb begin
    o_Pending_Mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) o_Pending_Mask = o_Pending_Mask | addr_one_hot(entry_addr[i]);
    end
    o_Pending_Mask[0] = 1'b0;
  end

  // Next-state: sweep sequencing and head starvation tracking
  always_comb begin
    state_n     = state_q;
    sweep_n     = sweep_q;
    starve_n    = starve_q;
    init_done_n = init_done_q;
    stall_n     = stall_q;
    case (state_q)
      ST_CLEAR: begin
        sweep_n = sweep_q + REG_ADDR_WIDTH'(1);
        if (sweep_q == SWEEP_LAST) begin
          state_n     = ST_RUN;
          init_done_n = 1'b1;
        end
      end
      ST_RUN: begin
        if (fifo_empty || pop) begin
          starve_n = '0;
        end else if (starve_q < STARVE_MAX) begin
          starve_n = starve_q + STARVE_CNT_WIDTH'(1);
        end
        // One cycle behind the counter; holds while the head keeps waiting
        stall_n = (starve_q == STARVE_MAX) && !pop;
      end
      default: state_n = ST_CLEAR;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= ST_CLEAR;
      sweep_q     <= SWEEP_FIRST;
      starve_q    <= '0;
      init_done_q <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      sweep_q     <= sweep_n;
      starve_q    <= starve_n;
      init_done_q <= init_done_n;
      stall_q     <= stall_n;
    end
  end

  assign o_Aux_Ready = aux_ready;
  assign o_Init_Done = init_done_q;
  assign o_Stall_Req = stall_q;

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Self-checking bench for reg_file_write_arbiter: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_reg_file_write_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        rf_en;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        init_done;
  logic [31:0] pending;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_Clock           (clk),
    .i_Reset           (rst),
    .i_WB_Valid        (wb_valid),
    .i_WB_Addr         (wb_addr),
    .i_WB_Data         (wb_data),
    .i_Aux_Valid       (aux_valid),
    .o_Aux_Ready       (aux_ready),
    .i_Aux_Addr        (aux_addr),
    .i_Aux_Data        (aux_data),
    .o_RF_Enable       (rf_en),
    .o_RF_Write_Enable (rf_we),
    .o_RF_Write_Addr   (rf_addr),
    .o_RF_Write_Data   (rf_data),
    .o_Init_Done       (init_done),
    .o_Pending_Mask    (pending),
    .o_Stall_Req       (stall)
  );

  // Reference model: ordered list of queued aux writes, how long the current
  // head has been waiting, and the stall flag the hazard logic should see.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          waited;
  logic        stall_m;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        exp_ready;
  logic [31:0] exp_mask;
  logic        exp_stall;

  task automatic model_clear();
    q.delete();
    waited  = 0;
    stall_m = 1'b0;
  endtask

  // Drive one RUN-mode cycle, predict its outputs, then advance the model.
  task automatic apply(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic auxv, input logic [4:0] auxa, input logic [31:0] auxd);
    logic popped;
    ent_t e;
    @(negedge clk);
    wb_valid  = wbv;
    wb_addr   = wba;
    wb_data   = wbd;
    aux_valid = auxv;
    aux_addr  = auxa;
    aux_data  = auxd;
    #1;
    exp_ready = (q.size() < 2);
    exp_mask  = '0;
    foreach (q[i]) exp_mask[q[i].a] = 1'b1;
    exp_stall = stall_m;
    popped    = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    if (wbv) begin
      exp_we   = 1'b1;
      exp_addr = wba;
      exp_data = wbd;
    end else if (q.size() > 0) begin
      exp_we   = 1'b1;
      exp_addr = q[0].a;
      exp_data = q[0].d;
      popped   = 1'b1;
    end
    stall_m = (q.size() > 0) && !popped && (waited >= LIMIT);
    if (popped || q.size() == 0) waited = 0;
    else if (waited < LIMIT) waited++;
    if (popped) void'(q.pop_front());
    if (auxv && exp_ready && auxa != 5'd0) begin
      e.a = auxa;
      e.d = auxd;
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234_5678; aux_valid = 1'b0;
    #1;
    checks++;
    if ({rf_en, rf_we, rf_addr, rf_data} !== 39'h0) begin
      errors++;
      $display("FAIL reset_port got en=%b we=%b addr=%0d data=%h exp all zero", rf_en, rf_we, rf_addr, rf_data);
    end
    @(negedge clk);
    checks++;
    if ({init_done, stall, aux_ready, pending} !== 35'h0) begin
      errors++;
      $display("FAIL reset_regs got init=%b stall=%b ready=%b mask=%h exp all zero", init_done, stall, aux_ready, pending);
    end
    rst = 1'b0;
    model_clear();
  endtask

  // Starts in the first cycle after reset release
  task automatic test_sweep();
    for (int c = 1; c <= 31; c++) begin
      wb_valid  = 1'($urandom_range(0, 1));
      wb_addr   = 5'($urandom);
      wb_data   = $urandom;
      aux_valid = 1'($urandom_range(0, 1));
      aux_addr  = 5'($urandom_range(1, 31));
      aux_data  = $urandom;
      #1;
      checks++;
      if ({rf_we, rf_addr, rf_data, init_done, aux_ready} !== {1'b1, 5'(c), 32'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL sweep c=%0d got we=%b addr=%0d data=%h init=%b ready=%b exp we=1 addr=%0d data=0 init=0 ready=0",
                 c, rf_we, rf_addr, rf_data, init_done, aux_ready, c);
      end
      @(negedge clk);
    end
    wb_valid  = 1'b0;
    aux_valid = 1'b0;
    #1;
    checks++;
    if ({init_done, rf_we, rf_en, aux_ready, pending} !== {1'b1, 1'b0, 1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL sweep_done got init=%b we=%b en=%b ready=%b mask=%h exp init=1 we=0 en=1 ready=1 mask=0",
               init_done, rf_we, rf_en, aux_ready, pending);
    end
  endtask

  task automatic test_wb();
    apply(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({rf_en, rf_we, rf_addr, rf_data} !== {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL wb_x5 got en=%b we=%b addr=%0d data=%h exp en=1 we=1 addr=5 data=deadbeef", rf_en, rf_we, rf_addr, rf_data);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 5'($urandom), $urandom, 1'b0, 5'd0, 32'h0);
      checks++;
      if ({rf_we, rf_addr, rf_data} !== {exp_we, exp_addr, exp_data}) begin
        errors++;
        $display("FAIL wb_rand i=%0d got we=%b addr=%0d data=%h exp we=%b addr=%0d data=%h",
                 i, rf_we, rf_addr, rf_data, exp_we, exp_addr, exp_data);
      end
    end
  endtask

  task automatic test_aux_idle();
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
    checks++;
    if ({aux_ready, rf_we, pending} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL aux_accept got ready=%b we=%b mask=%h exp ready=1 we=0 mask=0", aux_ready, rf_we, pending);
    end
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({pending, rf_we, rf_addr, rf_data} !== {32'h0000_0080, 1'b1, 5'd7, 32'h11}) begin
      errors++;
      $display("FAIL aux_write got mask=%h we=%b addr=%0d data=%h exp mask=00000080 we=1 addr=7 data=11",
               pending, rf_we, rf_addr, rf_data);
    end
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({pending, rf_we} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL aux_after got mask=%h we=%b exp mask=0 we=0", pending, rf_we);
    end
  endtask

  task automatic test_aux_x0();
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hABCD_0123);
    checks++;
    if (aux_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready got %b exp 1", aux_ready);
    end
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({pending, rf_we} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL x0_dropped got mask=%h we=%b exp mask=0 we=0", pending, rf_we);
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b1, 5'($urandom), $urandom, 1'b1, 5'd3, 32'h3333_0003);
    // k counts cycles from the first cycle x3 is blocked by writeback
    for (int k = 0; k <= LIMIT + 2; k++) begin
      apply(1'b1, 5'($urandom), $urandom, 1'b1, (k == 0) ? 5'd4 : 5'($urandom_range(1, 31)), 32'h4444_0004);
      checks++;
      if ({aux_ready, stall} !== {(k == 0), (k >= LIMIT + 1)} || stall !== exp_stall) begin
        errors++;
        $display("FAIL b2b k=%0d got ready=%b stall=%b exp ready=%b stall=%b",
                 k, aux_ready, stall, (k == 0), (k >= LIMIT + 1));
      end
    end
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({rf_we, rf_addr, rf_data, stall, pending} !== {1'b1, 5'd3, 32'h3333_0003, 1'b1, 32'h0000_0018}) begin
      errors++;
      $display("FAIL b2b_drain_x3 got we=%b addr=%0d data=%h stall=%b mask=%h exp we=1 addr=3 data=33330003 stall=1 mask=00000018",
               rf_we, rf_addr, rf_data, stall, pending);
    end
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({rf_we, rf_addr, rf_data, stall} !== {1'b1, 5'd4, 32'h4444_0004, 1'b0}) begin
      errors++;
      $display("FAIL b2b_drain_x4 got we=%b addr=%0d data=%h stall=%b exp we=1 addr=4 data=44440004 stall=0",
               rf_we, rf_addr, rf_data, stall);
    end
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({rf_we, pending} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL b2b_empty got we=%b mask=%h exp we=0 mask=0", rf_we, pending);
    end
  endtask

  task automatic test_random();
    int wb_pct;
    for (int i = 0; i < 400; i++) begin
      wb_pct = ((i / 50) % 2 == 1) ? 92 : 35;
      apply(1'($urandom_range(0, 99) < wb_pct), 5'($urandom), $urandom,
            1'($urandom_range(0, 99) < 60), 5'($urandom), $urandom);
      checks++;
      if (rf_we !== exp_we || (exp_we && {rf_addr, rf_data} !== {exp_addr, exp_data})) begin
        errors++;
        $display("FAIL rand_port i=%0d got we=%b addr=%0d data=%h exp we=%b addr=%0d data=%h",
                 i, rf_we, rf_addr, rf_data, exp_we, exp_addr, exp_data);
      end
      checks++;
      if ({aux_ready, stall, pending, rf_en} !== {exp_ready, exp_stall, exp_mask, 1'b1}) begin
        errors++;
        $display("FAIL rand_status i=%0d got ready=%b stall=%b mask=%h en=%b exp ready=%b stall=%b mask=%h en=1",
                 i, aux_ready, stall, pending, rf_en, exp_ready, exp_stall, exp_mask);
      end
    end
    // drain whatever the random run left queued
    for (int i = 0; i < 3; i++) apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset_mid();
    apply(1'b1, 5'($urandom), $urandom, 1'b1, 5'd9, 32'h9999_9999);
    apply(1'b1, 5'($urandom), $urandom, 1'b1, 5'd10, 32'hAAAA_AAAA);
    apply(1'b1, 5'($urandom), $urandom, 1'b0, 5'd0, 32'h0);
    checks++;
    if (pending !== 32'h0000_0600) begin
      errors++;
      $display("FAIL mid_queued got mask=%h exp 00000600", pending);
    end
    test_reset();
    test_sweep();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++;
      if ({rf_we, pending} !== {1'b0, 32'h0}) begin
        errors++;
        $display("FAIL mid_lost i=%0d got we=%b addr=%0d mask=%h exp we=0 mask=0", i, rf_we, rf_addr, pending);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    aux_valid = 1'b0;
    aux_addr  = '0;
    aux_data  = '0;
    model_clear();
    test_reset();
    test_sweep();
    test_wb();
    test_aux_idle();
    test_aux_x0();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
